// File: rtl/psec5_readout_pkg.sv
// Shared constants, state type and byte-select helper for the per-channel
// readout serializers that sit behind the SPI register interface.
package psec5_readout_pkg;

  localparam int NUM_REGS = 7;
  localparam int REG_W    = 8;
  localparam int SEL_W    = 3;
  localparam int NUM_CH   = 8;
  localparam int CNT_W    = $clog2(REG_W);

  localparam logic [SEL_W-1:0] SEL_INVALID = 3'b111;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  // Out-of-range indices yield zero so an invalid select shifts out a blank frame.
  function automatic logic [REG_W-1:0] byte_sel(
    input logic [NUM_REGS*REG_W-1:0] vec,
    input logic [SEL_W-1:0]          idx
  );
    logic [REG_W-1:0] result;
    result = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == SEL_W'(k)) begin
        result = vec[k*REG_W +: REG_W];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cnt_ser.sv
// One channel's readout serializer: snapshots the channel bytes on load and
// shifts the selected byte out MSB-first, reloading at each byte boundary.
module cnt_ser
  import psec5_readout_pkg::*;
(
  input  logic                      sclk,
  input  logic                      rstn,
  input  logic                      load,
  input  logic [SEL_W-1:0]          select_reg,
  input  logic [NUM_REGS*REG_W-1:0] data_in,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      byte_done,
  output logic                      snap_valid
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_W - 1);

  state_e                    state_q;
  logic [NUM_REGS*REG_W-1:0] snapshot_q;
  logic [REG_W-1:0]          shift_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic                      snap_valid_q;

  // data_in is only sampled on the IDLE->SHIFT edge; every later byte comes from the snapshot.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      snapshot_q   <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            snapshot_q   <= data_in;
            shift_q      <= byte_sel(data_in, select_reg);
            bit_cnt_q    <= '0;
            snap_valid_q <= 1'b1;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (!load) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            snap_valid_q <= 1'b0;
          end else if (bit_cnt_q == LAST_BIT) begin
            shift_q   <= byte_sel(snapshot_q, select_reg);
            bit_cnt_q <= '0;
          end else begin
            shift_q   <= {shift_q[REG_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial_out = shift_q[REG_W-1];
  assign busy       = (state_q == SHIFT);
  assign byte_done  = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
  assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_cnt_ser.sv
// Randomized scoreboard bench for cnt_ser: the driver pushes the expected
// output word for every clock edge and a negedge monitor pops and compares.
module tb_cnt_ser;

  logic        sclk;
  logic        rstn;
  logic        load;
  logic [2:0]  select_reg;
  logic [55:0] data_in;
  logic        serial_out;
  logic        busy;
  logic        byte_done;
  logic        snap_valid;

  int checks = 0;
  int errors = 0;

  // expected {serial_out, busy, byte_done, snap_valid} after each edge
  logic [3:0] expQ[$];
  logic [2:0] selList[8];
  int         otherData;

  cnt_ser dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .load       (load),
    .select_reg (select_reg),
    .data_in    (data_in),
    .serial_out (serial_out),
    .busy       (busy),
    .byte_done  (byte_done),
    .snap_valid (snap_valid)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  function automatic logic [55:0] randData();
    return {$urandom(), $urandom()} & 56'hFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [7:0] expByte(input logic [55:0] d, input logic [2:0] sel);
    if (sel >= 3'd7) return 8'h00;
    return 8'(d >> (int'(sel) * 8));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One clock edge: drive inputs, and record what the outputs must be after it.
  task automatic applyStimulus(input logic ld, input logic [2:0] sel,
                               input logic [55:0] d, input logic [3:0] e);
    load       = ld;
    select_reg = sel;
    data_in    = d;
    @(posedge sclk);
    expQ.push_back(e);
    #2;
  endtask

  task automatic idleEdges(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 3'($urandom_range(0, 7)), randData(), 4'b0000);
  endtask

  // Read session: load snapshot d, run nbits serial bits using selList, then drop load.
  task automatic session(input logic [55:0] d, input int nbits);
    logic [7:0] v;
    logic [2:0] sel;
    logic [55:0] drv;
    for (int t = 0; t < nbits; t++) begin
      int j = t / 8;
      int b = t % 8;
      v   = expByte(d, selList[j]);
      sel = (b == 0) ? selList[j] : 3'($urandom_range(0, 7));
      if (t == 0) drv = d;
      else if (otherData == 1) drv = {56{1'b1}};
      else drv = randData();
      applyStimulus(1'b1, sel, drv, {v[7-b], 1'b1, (b == 7), 1'b1});
    end
    applyStimulus(1'b0, 3'($urandom_range(0, 7)), randData(), 4'b0000);
  endtask

  task automatic midReset(input logic [55:0] d, input int nbits);
    logic [7:0] v;
    v = expByte(d, selList[0]);
    for (int t = 0; t < nbits; t++)
      applyStimulus(1'b1, (t == 0) ? selList[0] : 3'd0, d, {v[7-t], 1'b1, (t == 7), 1'b1});
    void'(expQ.pop_back());
    expQ.push_back(4'b0000);
    rstn = 1'b0;
    #1;
    checkOutput("asyncReset", {28'd0, serial_out, busy, byte_done, snap_valid}, 32'd0);
    applyStimulus(1'b1, 3'd0, d, 4'b0000);
    rstn = 1'b1;
    idleEdges(2);
  endtask

  initial begin
    forever begin
      @(negedge sclk);
      if (expQ.size() > 0) begin
        logic [3:0] e;
        e = expQ.pop_front();
        checkOutput("outputs{ser,busy,done,snap}",
                    {28'd0, serial_out, busy, byte_done, snap_valid}, {28'd0, e});
      end
    end
  end

  initial begin
    logic [55:0] seq;
    logic [55:0] d;
    rstn       = 1'b0;
    load       = 1'b0;
    select_reg = 3'b111;
    data_in    = '0;
    otherData  = 0;
    #1;
    checkOutput("resetState", {28'd0, serial_out, busy, byte_done, snap_valid}, 32'd0);
    @(posedge sclk);
    #2;
    rstn = 1'b1;

    idleEdges(20);

    selList[0] = 3'd0;
    session(56'h00_0000_0000_00A5, 8);

    seq = 56'h40_2010_0804_0201;
    for (int i = 0; i < 7; i++) selList[i] = 3'(i);
    session(seq, 56);

    otherData = 1;
    session(seq, 56);
    otherData = 0;
    session({56{1'b1}}, 56);

    selList[0] = 3'b111;
    selList[1] = 3'd3;
    session({56{1'b1}}, 16);

    selList[0] = 3'd2;
    session(56'h00_0000_003C_0000, 3);
    session(56'h00_0000_003C_0000, 8);

    selList[0] = 3'd5;
    midReset(randData(), 5);

    for (int r = 0; r < 30; r++) begin
      int nb = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) selList[i] = 3'($urandom_range(0, 7));
      otherData = $urandom_range(0, 1);
      d = randData();
      session(d, $urandom_range(1, nb * 8));
      if ($urandom_range(0, 3) == 0) idleEdges($urandom_range(1, 3));
    end

    repeat (3) @(negedge sclk);
    #1;
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
